// File: rtl/data_memory.sv
// ============================================================================
// data_memory
// ----------------------------------------------------------------------------
// Data-memory responder for the core's MEM-stage port. The memory is organised
// as 32-bit words with byte lanes. Loads are combinational and stores take
// effect at the rising edge. A sticky error flag records misaligned and
// out-of-range accesses. A backdoor port lets a bench preload and inspect
// the array.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (clears err/err_addr only)
//   mem_addr   in   byte address of the core access
//   mem_cmd    in   1=LB 2=LH 3=LW 4=LBU 5=LHU 9=SB A=SH B=SW, others = none
//   mem_din    in   right-aligned store data
//   mem_dout   out  right-aligned, sign/zero-extended load data (0 otherwise)
//   err        out  sticky access-error flag
//   err_addr   out  address of the first erroring access
//   err_clr    in   synchronous clear of err/err_addr (a new error wins)
//   bd_we      in   backdoor full-word write enable
//   bd_addr    in   backdoor byte address, bits [1:0] ignored
//   bd_wdata   in   backdoor write data
//   bd_rdata   out  backdoor combinational read data (0 when out of range)
//
// Optional build macro DMEM_STATS_EN adds the following ports:
//   stat_clr     in   synchronous clear of all counters
//   stat_loads   out  good-load count (wraps)
//   stat_stores  out  good-store count (wraps)
//   stat_errs    out  erroring-access count (saturates at 16'hFFFF)
// ============================================================================
module data_memory #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_cmd,
   input  logic [31:0] mem_din,
   output logic [31:0] mem_dout,
   output logic        err,
   output logic [31:0] err_addr,
   input  logic        err_clr,
   input  logic        bd_we,
   input  logic [31:0] bd_addr,
   input  logic [31:0] bd_wdata,
`ifdef DMEM_STATS_EN
   input  logic        stat_clr,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [15:0] stat_errs,
`endif
   output logic [31:0] bd_rdata
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   // The span is 33 bits wide so that an array covering the whole 4 GiB space
   // still compares correctly.
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

   localparam logic [3:0] CMD_LB  = 4'h1;
   localparam logic [3:0] CMD_LH  = 4'h2;
   localparam logic [3:0] CMD_LW  = 4'h3;
   localparam logic [3:0] CMD_LBU = 4'h4;
   localparam logic [3:0] CMD_LHU = 4'h5;
   localparam logic [3:0] CMD_SB  = 4'h9;
   localparam logic [3:0] CMD_SH  = 4'hA;
   localparam logic [3:0] CMD_SW  = 4'hB;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   logic [31:0]   mem_r [DEPTH_WORDS];

   logic          ld_s;
   logic          st_s;
   logic          sext_s;
   logic [1:0]    size_s;
   logic [31:0]   offset_s;
   logic          in_range_s;
   logic [AW-1:0] idx_s;
   logic          misalign_s;
   logic          acc_err_s;
   logic [31:0]   rd_word_s;
   logic [7:0]    ld_byte_s;
   logic [15:0]   ld_half_s;
   logic [31:0]   ld_data_s;
   logic [3:0]    st_be_s;
   logic [31:0]   st_data_s;
   logic          st_go_s;
   logic [31:0]   bd_off_s;
   logic          bd_in_range_s;
   logic [AW-1:0] bd_idx_s;
   logic          bd_go_s;
   logic          same_word_s;
   logic [31:0]   st_word_s;
   logic [31:0]   bd_word_s;
   logic          err_r;
   logic [31:0]   err_addr_r;

   // Command decode: access class, access size and extension mode.
   always_comb begin
      ld_s   = 1'b0;
      st_s   = 1'b0;
      sext_s = 1'b0;
      size_s = SZ_B;
      case (mem_cmd)
         CMD_LB:  begin ld_s = 1'b1; size_s = SZ_B; sext_s = 1'b1; end
         CMD_LH:  begin ld_s = 1'b1; size_s = SZ_H; sext_s = 1'b1; end
         CMD_LW:  begin ld_s = 1'b1; size_s = SZ_W; end
         CMD_LBU: begin ld_s = 1'b1; size_s = SZ_B; end
         CMD_LHU: begin ld_s = 1'b1; size_s = SZ_H; end
         CMD_SB:  begin st_s = 1'b1; size_s = SZ_B; end
         CMD_SH:  begin st_s = 1'b1; size_s = SZ_H; end
         CMD_SW:  begin st_s = 1'b1; size_s = SZ_W; end
         default: begin ld_s = 1'b0; st_s = 1'b0; end
      endcase
   end

   // Address range check, word index and alignment check for the core port.
   always_comb begin
      offset_s   = mem_addr - BASE_ADDR;
      in_range_s = ({1'b0, offset_s} < SPAN_BYTES);
      idx_s      = offset_s[AW+1:2];
      case (size_s)
         SZ_H:    misalign_s = mem_addr[0];
         SZ_W:    misalign_s = |mem_addr[1:0];
         default: misalign_s = 1'b0;
      endcase
      acc_err_s = (ld_s | st_s) & (misalign_s | ~in_range_s);
   end

   // Load path: pick the addressed lane(s) and extend them. Erroring and
   // non-load cycles return zero.
   always_comb begin
      rd_word_s = mem_r[idx_s];
      case (mem_addr[1:0])
         2'd0:    ld_byte_s = rd_word_s[7:0];
         2'd1:    ld_byte_s = rd_word_s[15:8];
         2'd2:    ld_byte_s = rd_word_s[23:16];
         2'd3:    ld_byte_s = rd_word_s[31:24];
         default: ld_byte_s = 8'h00;
      endcase
      if (mem_addr[1]) begin
         ld_half_s = rd_word_s[31:16];
      end else begin
         ld_half_s = rd_word_s[15:0];
      end
      case (size_s)
         SZ_B:    ld_data_s = sext_s ? {{24{ld_byte_s[7]}}, ld_byte_s}
                                     : {24'h00_0000, ld_byte_s};
         SZ_H:    ld_data_s = sext_s ? {{16{ld_half_s[15]}}, ld_half_s}
                                     : {16'h0000, ld_half_s};
         SZ_W:    ld_data_s = rd_word_s;
         default: ld_data_s = 32'h0000_0000;
      endcase
      if (ld_s && !acc_err_s) begin
         mem_dout = ld_data_s;
      end else begin
         mem_dout = 32'h0000_0000;
      end
   end

   // Store lane enables; data is replicated so that every lane sees its byte.
   always_comb begin
      case (size_s)
         SZ_B: begin
            st_be_s   = 4'b0001 << mem_addr[1:0];
            st_data_s = {4{mem_din[7:0]}};
         end
         SZ_H: begin
            st_be_s   = mem_addr[1] ? 4'b1100 : 4'b0011;
            st_data_s = {2{mem_din[15:0]}};
         end
         SZ_W: begin
            st_be_s   = 4'b1111;
            st_data_s = mem_din;
         end
         default: begin
            st_be_s   = 4'b0000;
            st_data_s = 32'h0000_0000;
         end
      endcase
      st_go_s = st_s & ~acc_err_s & ~rst;
   end

   // Backdoor decode and read. Bits [1:0] of bd_addr only affect the range
   // test through the subtraction, never the index.
   always_comb begin
      bd_off_s      = bd_addr - BASE_ADDR;
      bd_in_range_s = ({1'b0, bd_off_s} < SPAN_BYTES);
      bd_idx_s      = bd_off_s[AW+1:2];
      bd_go_s       = bd_we & bd_in_range_s & ~rst;
      if (bd_in_range_s) begin
         bd_rdata = mem_r[bd_idx_s];
      end else begin
         bd_rdata = 32'h0000_0000;
      end
   end

   // Write merge. When the core store and the backdoor hit the same word, the
   // backdoor write carries the store lanes and the store write is dropped.
   // This lets the core store win on the lanes it writes.
   always_comb begin
      same_word_s = st_go_s & bd_go_s & (idx_s == bd_idx_s);
      for (int i = 0; i < 4; i++) begin
         if (st_be_s[i]) begin
            st_word_s[8*i +: 8] = st_data_s[8*i +: 8];
         end else begin
            st_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
         end
         if (same_word_s && st_be_s[i]) begin
            bd_word_s[8*i +: 8] = st_data_s[8*i +: 8];
         end else begin
            bd_word_s[8*i +: 8] = bd_wdata[8*i +: 8];
         end
      end
   end

   // Array update. Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (bd_go_s) begin
         mem_r[bd_idx_s] <= bd_word_s;
      end
      if (st_go_s && !same_word_s) begin
         mem_r[idx_s] <= st_word_s;
      end
   end

   // Sticky error capture. A new error wins over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r      <= 1'b0;
         err_addr_r <= 32'h0000_0000;
      end else if (acc_err_s && (!err_r || err_clr)) begin
         err_r      <= 1'b1;
         err_addr_r <= mem_addr;
      end else if (err_clr) begin
         err_r      <= 1'b0;
         err_addr_r <= 32'h0000_0000;
      end
   end

   assign err      = err_r;
   assign err_addr = err_addr_r;

`ifdef DMEM_STATS_EN
   logic [31:0] stat_loads_r;
   logic [31:0] stat_stores_r;
   logic [15:0] stat_errs_r;

   // Access statistics. Erroring accesses count only as errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_loads_r  <= 32'h0000_0000;
         stat_stores_r <= 32'h0000_0000;
         stat_errs_r   <= 16'h0000;
      end else if (stat_clr) begin
         stat_loads_r  <= 32'h0000_0000;
         stat_stores_r <= 32'h0000_0000;
         stat_errs_r   <= 16'h0000;
      end else begin
         if (ld_s && !acc_err_s) begin
            stat_loads_r <= stat_loads_r + 32'd1;
         end
         if (st_s && !acc_err_s) begin
            stat_stores_r <= stat_stores_r + 32'd1;
         end
         if (acc_err_s && (stat_errs_r != 16'hFFFF)) begin
            stat_errs_r <= stat_errs_r + 16'd1;
         end
      end
   end

   assign stat_loads  = stat_loads_r;
   assign stat_stores = stat_stores_r;
   assign stat_errs   = stat_errs_r;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_memory.sv
// ============================================================================
// tb_data_memory
// ----------------------------------------------------------------------------
// Directed bench for data_memory. A byte-addressed reference model tracks the
// array, the sticky error state and the expected load data. A negedge
// process compares every cycle against that model. Literal expectations
// taken from the hand-worked examples pin the model itself.
// ============================================================================
module tb_data_memory;

   localparam int          DW   = 1024;
   localparam int          NB   = DW * 4;
   localparam logic [31:0] BASE = 32'h0000_0000;

   localparam logic [3:0] NONE = 4'h0;
   localparam logic [3:0] LB   = 4'h1;
   localparam logic [3:0] LH   = 4'h2;
   localparam logic [3:0] LW   = 4'h3;
   localparam logic [3:0] LBU  = 4'h4;
   localparam logic [3:0] LHU  = 4'h5;
   localparam logic [3:0] SB   = 4'h9;
   localparam logic [3:0] SH   = 4'hA;
   localparam logic [3:0] SW   = 4'hB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [3:0]  mem_cmd = 4'h0;
   logic [31:0] mem_din = 32'h0;
   logic [31:0] mem_dout;
   logic        err;
   logic [31:0] err_addr;
   logic        err_clr = 1'b0;
   logic        bd_we = 1'b0;
   logic [31:0] bd_addr = 32'h0;
   logic [31:0] bd_wdata = 32'h0;
   logic [31:0] bd_rdata;
`ifdef DMEM_STATS_EN
   logic        stat_clr = 1'b0;
   logic [31:0] stat_loads;
   logic [31:0] stat_stores;
   logic [15:0] stat_errs;
`endif

   data_memory #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_din(mem_din),
      .mem_dout(mem_dout), .err(err), .err_addr(err_addr), .err_clr(err_clr),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
`ifdef DMEM_STATS_EN
      .stat_clr(stat_clr), .stat_loads(stat_loads),
      .stat_stores(stat_stores), .stat_errs(stat_errs),
`endif
      .bd_rdata(bd_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: a byte array with a known flag per byte.
   logic [7:0]  mb [NB];
   bit          mk [NB];
   bit          mdl_err = 1'b0;
   logic [31:0] mdl_err_addr = 32'h0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int acc_width(input logic [3:0] c);
      case (c)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic bit is_ld(input logic [3:0] c);
      return (c >= LB) && (c <= LHU);
   endfunction

   function automatic bit is_st(input logic [3:0] c);
      return (c == SB) || (c == SH) || (c == SW);
   endfunction

   function automatic bit acc_bad(input logic [3:0] c, input logic [31:0] a);
      int w;
      w = acc_width(c);
      if (w == 0) return 1'b0;
      return ((a - BASE) >= 32'(NB)) || ((a & 32'(w - 1)) != 32'h0);
   endfunction

   function automatic void exp_load(input logic [3:0] c, input logic [31:0] a,
                                    output logic [31:0] v, output bit k);
      int w;
      int o;
      w = acc_width(c);
      v = 32'h0;
      k = 1'b1;
      if (!is_ld(c) || acc_bad(c, a)) return;
      o = int'(a - BASE);
      for (int i = 0; i < w; i++) begin
         if (!mk[o + i]) k = 1'b0;
         v[8*i +: 8] = mb[o + i];
      end
      if ((c == LB) && v[7])  v[31:8]  = 24'hFF_FFFF;
      if ((c == LH) && v[15]) v[31:16] = 16'hFFFF;
   endfunction

   function automatic void exp_bd(input logic [31:0] a, output logic [31:0] v, output bit k);
      logic [31:0] off;
      int o;
      v = 32'h0;
      k = 1'b1;
      off = a - BASE;
      if (off >= 32'(NB)) return;
      o = int'(off) & ~3;
      for (int i = 0; i < 4; i++) begin
         if (!mk[o + i]) k = 1'b0;
         v[8*i +: 8] = mb[o + i];
      end
   endfunction

   // Apply the edge effects of the current inputs to the model.
   task automatic commit();
      logic [31:0] off;
      int o;
      int w;
      if (rst) return;
      off = bd_addr - BASE;
      if (bd_we && (off < 32'(NB))) begin
         o = int'(off) & ~3;
         for (int i = 0; i < 4; i++) begin
            mb[o + i] = bd_wdata[8*i +: 8];
            mk[o + i] = 1'b1;
         end
      end
      w = acc_width(mem_cmd);
      if (is_st(mem_cmd) && !acc_bad(mem_cmd, mem_addr)) begin
         o = int'(mem_addr - BASE);
         for (int i = 0; i < w; i++) begin
            mb[o + i] = mem_din[8*i +: 8];
            mk[o + i] = 1'b1;
         end
      end
      if (acc_bad(mem_cmd, mem_addr) && (!mdl_err || err_clr)) begin
         mdl_err      = 1'b1;
         mdl_err_addr = mem_addr;
      end else if (err_clr) begin
         mdl_err      = 1'b0;
         mdl_err_addr = 32'h0;
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] e;
      bit k;
      if (chk_en) begin
         exp_load(mem_cmd, mem_addr, e, k);
         if (k) check("mem_dout", mem_dout, e);
         exp_bd(bd_addr, e, k);
         if (k) check("bd_rdata", bd_rdata, e);
         check("err", {31'h0, err}, {31'h0, mdl_err});
         check("err_addr", err_addr, mdl_err_addr);
      end
   end

   // One cycle: drive, optional literal checks at negedge, model commit at edge.
   task automatic vec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                      input logic bw, input logic [31:0] ba, input logic [31:0] bdat,
                      input logic clr, input logic [1:0] lm,
                      input logic [31:0] ld, input logic [31:0] lb);
      mem_cmd = c; mem_addr = a; mem_din = d;
      bd_we = bw; bd_addr = ba; bd_wdata = bdat; err_clr = clr;
      @(negedge clk);
      if (lm[0]) check("lit_dout", mem_dout, ld);
      if (lm[1]) check("lit_bd_rdata", bd_rdata, lb);
      @(posedge clk);
      commit();
      #1;
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         mb[i] = 8'h00;
         mk[i] = 1'b0;
      end
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      check("reset_err", {31'h0, err}, 32'h0);
      check("reset_err_addr", err_addr, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Preload words 0..15 with zero, then the byte-lane pattern in word 0.
      for (int i = 0; i < 16; i++)
         vec(NONE, 32'h0, 32'h0, 1'b1, 32'(i * 4), 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(NONE, 32'h0, 32'h0, 1'b1, 32'h0, 32'h8081_7F01, 1'b0, 2'b00, 32'h0, 32'h0);

      // Load extraction and extension.
      vec(LB,  32'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b11, 32'h0000_007F, 32'h8081_7F01);
      vec(LB,  32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0000_0001, 32'h0);
      vec(LB,  32'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hFFFF_FF80, 32'h0);
      vec(LHU, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0000_8081, 32'h0);
      vec(LH,  32'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hFFFF_8081, 32'h0);
      vec(LBU, 32'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0000_0080, 32'h0);
      vec(LH,  32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0000_7F01, 32'h0);

      // Stores with byte lanes.
      vec(SW, 32'd8, 32'h1122_3344, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 32'h0);
      vec(SB, 32'd9, 32'h0000_00AA, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LW, 32'd8, 32'h0, 1'b0, 32'd8, 32'h0, 1'b0, 2'b11, 32'h1122_AA44, 32'h1122_AA44);
      vec(SH, 32'd14, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LW, 32'd12, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hBEEF_0000, 32'h0);

      // Read-during-write: the backdoor sees old data in the store cycle.
      vec(SW, 32'd4, 32'hDEAD_BEEF, 1'b0, 32'd4, 32'h0, 1'b0, 2'b11, 32'h0, 32'h0);
      vec(LW, 32'd4, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hDEAD_BEEF, 32'h0);

      // Misaligned store: no write, sticky first address, clear.
      vec(SW, 32'd6, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      check("err_set", {31'h0, err}, 32'h1);
      check("err_addr_6", err_addr, 32'd6);
      vec(LW, 32'd4, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hDEAD_BEEF, 32'h0);
      vec(LH, 32'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 32'h0);
      check("err_addr_held", err_addr, 32'd6);
      vec(NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      check("err_cleared", {31'h0, err}, 32'h0);
      // A new error coincident with a clear wins.
      vec(LW, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 32'h0);
      vec(LHU, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b01, 32'h0, 32'h0);
      check("err_clr_vs_new", err_addr, 32'd5);
      vec(NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      // A misaligned byte-lane store leaves word 0 untouched.
      vec(SH, 32'd1, 32'h0000_FFFF, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      vec(LW, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b01, 32'h8081_7F01, 32'h0);

      // Unknown command is a no-op even out of range.
      vec(4'hF, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 32'h0);
      check("unknown_cmd_no_err", {31'h0, err}, 32'h0);

      // Backdoor out of range: dropped, reads zero, no aliasing onto word 0.
      vec(NONE, 32'h0, 32'h0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 2'b10, 32'h0, 32'h0);
      vec(LW, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h8081_7F01, 32'h0);

      // Backdoor and core store to the same word: store lane wins.
      vec(SB, 32'd13, 32'h0000_0055, 1'b1, 32'd12, 32'h1122_3344, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LW, 32'd12, 32'h0, 1'b0, 32'd12, 32'h0, 1'b0, 2'b11, 32'h1122_5544, 32'h1122_5544);

      // Last word in range, then first word past the end.
      vec(SW, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LW, 32'h0000_0FFC, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hCAFE_F00D, 32'h0);
      vec(LW, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 32'h0);
      check("oor_err", {31'h0, err}, 32'h1);
      check("oor_err_addr", err_addr, 32'h0000_1000);

      // Reset mid-run: err clears, array kept, stores ignored during reset.
      vec(NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      #2 rst = 1'b1;
      mdl_err = 1'b0;
      mdl_err_addr = 32'h0;
      #1;
      check("midrun_rst_err", {31'h0, err}, 32'h0);
      check("midrun_rst_err_addr", err_addr, 32'h0);
      vec(SW, 32'd8, 32'h0, 1'b1, 32'd0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      rst = 1'b0;
      vec(LW, 32'd8, 32'h0, 1'b0, 32'd0, 32'h0, 1'b0, 2'b11, 32'h1122_AA44, 32'h8081_7F01);

`ifdef DMEM_STATS_EN
      stat_clr = 1'b1;
      vec(NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      stat_clr = 1'b0;
      vec(LW,  32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LB,  32'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(LHU, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(SW,  32'd16, 32'h0102_0304, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(SB,  32'd20, 32'h0000_0099, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      vec(SW,  32'd22, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      check("stat_loads", stat_loads, 32'd3);
      check("stat_stores", stat_stores, 32'd2);
      check("stat_errs", {16'h0, stat_errs}, 32'd1);
      stat_clr = 1'b1;
      vec(LW, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      stat_clr = 1'b0;
      check("stat_clr_loads", stat_loads, 32'd0);
      check("stat_clr_stores", stat_stores, 32'd0);
      check("stat_clr_errs", {16'h0, stat_errs}, 32'd0);
`endif

      vec(NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
